// File: rtl/nn_fixed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_fixed_pkg
//  Description : Shared fixed-point definitions for the backprop datapath.
//                Q6.10 constants, parameter-bank state encoding, and update
//                mode encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package nn_fixed_pkg;

    localparam int          FRAC_BITS = 10;
    localparam logic [15:0] ONE       = 16'h0400;
    localparam logic [15:0] NEG_ONE   = 16'hFC00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        APPLY = 2'd2
    } state_t;

    localparam logic DIRECT = 1'b0;
    localparam logic BATCH  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/param_bank_update_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : sat_add
//  Description : Signed saturating adder. Both operands are sign-extended to
//                a width that cannot overflow, added, then clamped to the
//                signed range of WO bits.
//  Ports       : a   [WA] signed operand
//                b   [WB] signed operand
//                sum [WO] clamped result
//                ovf       high when the result was clamped
//  Revision    : 1.0  initial release
// ============================================================================
module sat_add #(
    parameter int WA = 16,
    parameter int WB = 16,
    parameter int WO = 16
) (
    input  logic signed [WA-1:0] a,
    input  logic signed [WB-1:0] b,
    output logic signed [WO-1:0] sum,
    output logic                 ovf
);

    // One bit beyond the widest operand holds the exact sum; widen further
    // if the output is wider still so the clamp limits are representable.
    localparam int WS = ((WA > WB) ? WA : WB) + 1;
    localparam int WX = (WS > WO) ? WS : WO;

    localparam logic signed [WX-1:0] MAXV = {{(WX-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [WX-1:0] MINV = ~MAXV;

    logic signed [WX-1:0] w_a_ext;
    logic signed [WX-1:0] w_b_ext;
    logic signed [WX-1:0] w_full;

    assign w_a_ext = WX'(a);
    assign w_b_ext = WX'(b);
    assign w_full  = w_a_ext + w_b_ext;

    always_comb begin
        ovf = 1'b0;
        sum = w_full[WO-1:0];
        if (w_full > MAXV) begin
            sum = MAXV[WO-1:0];
            ovf = 1'b1;
        end else if (w_full < MINV) begin
            sum = MINV[WO-1:0];
            ovf = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/param_bank_update.sv
`default_nettype none
// ============================================================================
//  Module      : param_bank_update
//  Description : Bank of N signed Q6.10 trainable parameters. Supports a
//                one-cycle programmable init, immediate (DIRECT) saturating
//                updates, and BATCH accumulation with a scaled per-channel
//                apply sweep on commit.
//  Ports       : clk, reset          clock, synchronous active-high reset
//                init_start          load INIT_VALUES (IDLE only)
//                mode                0 = DIRECT, 1 = BATCH
//                upd_valid/upd_ready delta handshake
//                upd_idx, upd_delta  target channel and signed delta
//                commit              start BATCH apply sweep (IDLE only)
//                busy, done          status (registered)
//                sat_flag            sticky saturation indicator
//                param_out           packed parameters, entry i at [i*W +: W]
//  Revision    : 1.0  initial release
// ============================================================================
module param_bank_update
    import nn_fixed_pkg::*;
#(
    parameter int               N           = 4,
    parameter int               W           = 16,
    parameter int               ACC_GUARD   = 4,
    parameter int               SHIFT       = 0,
    parameter logic [N*W-1:0]   INIT_VALUES = {N{16'hFC00}},
    parameter int               IW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            init_start,
    input  logic            mode,
    input  logic            upd_valid,
    output logic            upd_ready,
    input  logic [IW-1:0]   upd_idx,
    input  logic [W-1:0]    upd_delta,
    input  logic            commit,
    output logic            busy,
    output logic            done,
    output logic            sat_flag,
    output logic [N*W-1:0]  param_out
);

    localparam int            ACC_W   = W + ACC_GUARD;
    localparam logic [IW-1:0] LAST_CH = IW'(N - 1);

    state_t                   r_state;
    logic [IW-1:0]            r_ch;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_sat;
    logic signed [W-1:0]      r_param [N];
    logic signed [ACC_W-1:0]  r_acc   [N];

    logic                     w_idx_ok;
    logic [IW-1:0]            w_idx_safe;
    logic [IW-1:0]            w_sel;
    logic signed [ACC_W-1:0]  w_p_b;
    logic signed [W-1:0]      w_p_sum;
    logic                     w_p_ovf;
    logic signed [ACC_W-1:0]  w_a_sum;
    logic                     w_a_ovf;
    logic                     w_accept;

    assign upd_ready = (r_state == IDLE) && !init_start && !commit;
    assign w_accept  = upd_valid && upd_ready;

    // Out-of-range indices (N not a power of two) are consumed but never
    // written; the safe index keeps array reads in bounds.
    assign w_idx_ok   = ({{(32-IW){1'b0}}, upd_idx} < 32'(N));
    assign w_idx_safe = w_idx_ok ? upd_idx : '0;

    // The param adder is shared: in APPLY it adds the scaled accumulator of
    // the swept channel, otherwise the sign-extended incoming delta.
    assign w_sel = (r_state == APPLY) ? r_ch : w_idx_safe;
    assign w_p_b = (r_state == APPLY) ? (r_acc[r_ch] >>> SHIFT)
                                      : ACC_W'($signed(upd_delta));

    sat_add #(.WA(W), .WB(ACC_W), .WO(W)) u_param_add (
        .a   (r_param[w_sel]),
        .b   (w_p_b),
        .sum (w_p_sum),
        .ovf (w_p_ovf)
    );

    sat_add #(.WA(ACC_W), .WB(W), .WO(ACC_W)) u_acc_add (
        .a   (r_acc[w_idx_safe]),
        .b   ($signed(upd_delta)),
        .sum (w_a_sum),
        .ovf (w_a_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_param[i] <= '0;
                r_acc[i]   <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (init_start) begin
                        r_state <= INIT;
                        r_busy  <= 1'b1;
                    end else if (commit) begin
                        r_state <= APPLY;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                    end else if (w_accept && w_idx_ok) begin
                        if (mode == DIRECT) begin
                            r_param[w_idx_safe] <= w_p_sum;
                            if (w_p_ovf) r_sat <= 1'b1;
                        end else begin
                            r_acc[w_idx_safe] <= w_a_sum;
                            if (w_a_ovf) r_sat <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    for (int i = 0; i < N; i++) begin
                        r_param[i] <= INIT_VALUES[i*W +: W];
                        r_acc[i]   <= '0;
                    end
                    r_sat   <= 1'b0;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                APPLY: begin
                    r_param[r_ch] <= w_p_sum;
                    r_acc[r_ch]   <= '0;
                    if (w_p_ovf) r_sat <= 1'b1;
                    if (r_ch == LAST_CH) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign param_out[gi*W +: W] = r_param[gi];
        end
    endgenerate

    assign busy     = r_busy;
    assign done     = r_done;
    assign sat_flag = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_param_bank_update.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_bank_update
//  Description : Self-checking bench for param_bank_update (N=4, W=16,
//                SHIFT=1). Table of single-cycle update vectors plus
//                hand-written init, commit, conflict and reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_bank_update;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            init_start;
    logic            mode;
    logic            upd_valid;
    logic            upd_ready;
    logic [IW-1:0]   upd_idx;
    logic [W-1:0]    upd_delta;
    logic            commit;
    logic            busy;
    logic            done;
    logic            sat_flag;
    logic [N*W-1:0]  param_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    param_bank_update #(.N(N), .W(W), .ACC_GUARD(4), .SHIFT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .init_start (init_start),
        .mode       (mode),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_idx    (upd_idx),
        .upd_delta  (upd_delta),
        .commit     (commit),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag),
        .param_out  (param_out)
    );

    typedef struct {
        logic        mode;
        logic        valid;
        logic [1:0]  idx;
        logic [15:0] delta;
        logic [63:0] exp_param;   // {p3, p2, p1, p0}
        logic        exp_sat;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        init_start = 1'b0;
        commit     = 1'b0;
        upd_valid  = 1'b0;
        mode       = 1'b0;
        upd_idx    = '0;
        upd_delta  = '0;
    endtask

    task automatic do_init(input string tag);
        init_start = 1'b1;
        #1;
        check({tag, "_init_ready_low"}, 64'(upd_ready), 64'd0);
        tick();
        init_start = 1'b0;
        check({tag, "_init_busy"}, 64'(busy), 64'd1);
        check({tag, "_init_done_early"}, 64'(done), 64'd0);
        tick();
        check({tag, "_init_param"}, param_out, {4{16'hFC00}});
        check({tag, "_init_done"}, 64'(done), 64'd1);
        check({tag, "_init_busy_off"}, 64'(busy), 64'd0);
        check({tag, "_init_sat"}, 64'(sat_flag), 64'd0);
        tick();
        check({tag, "_init_done_pulse"}, 64'(done), 64'd0);
    endtask

    // Commit and measure: done must appear exactly 5 edges after commit,
    // with busy and !upd_ready for the 4 APPLY cycles in between.
    task automatic do_commit(input string tag, input logic [63:0] exp_param);
        int done_at   = -1;
        int busy_cnt  = 0;
        int ready_low = 0;
        commit = 1'b1;
        #1;
        check({tag, "_commit_ready_low"}, 64'(upd_ready), 64'd0);
        for (int c = 1; c <= 12 && done_at < 0; c++) begin
            tick();
            commit = 1'b0;
            #1;
            if (busy) busy_cnt++;
            if (!upd_ready) ready_low++;
            if (done) begin
                done_at = c;
                checks++;
                if (busy) begin
                    failures++;
                    $display("FAIL %s_done_with_busy: busy=1 expected 0", tag);
                end
            end
        end
        check({tag, "_done_latency"}, 64'(done_at), 64'd5);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
        check({tag, "_ready_low_cycles"}, 64'(ready_low), 64'd4);
        check({tag, "_apply_param"}, param_out, exp_param);
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 2'd2, 16'h0100, {16'hFC00, 16'hFD00, 16'hFC00, 16'hFC00}, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 2'd2, 16'h0100, {16'hFC00, 16'hFE00, 16'hFC00, 16'hFC00}, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 2'd0, 16'h7FFF, {16'hFC00, 16'hFE00, 16'hFC00, 16'h7BFF}, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 2'd0, 16'h7FFF, {16'hFC00, 16'hFE00, 16'hFC00, 16'h7FFF}, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 2'd1, 16'h1234, {16'hFC00, 16'hFE00, 16'hFC00, 16'h7FFF}, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 16'h0400, {16'hFC00, 16'hFE00, 16'hFC00, 16'h7FFF}, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 2'd1, 16'h0400, {16'hFC00, 16'hFE00, 16'hFC00, 16'h7FFF}, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 2'd1, 16'h0400, {16'hFC00, 16'hFE00, 16'hFC00, 16'h7FFF}, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 2'd3, 16'hFFFF, {16'hFC00, 16'hFE00, 16'hFC00, 16'h7FFF}, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 2'd2, 16'h0100, {16'hFC00, 16'hFF00, 16'hFC00, 16'h7FFF}, 1'b1};

        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        tick();
        reset = 1'b0;
        #1;
        check("reset_param", param_out, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sat", 64'(sat_flag), 64'd0);
        check("reset_ready", 64'(upd_ready), 64'd1);
        @(negedge clk);

        do_init("first");

        for (int v = 0; v < 10; v++) begin
            mode      = vecs[v].mode;
            upd_valid = vecs[v].valid;
            upd_idx   = vecs[v].idx;
            upd_delta = vecs[v].delta;
            #1;
            check($sformatf("vec%0d_ready", v), 64'(upd_ready), 64'd1);
            tick();
            upd_valid = 1'b0;
            check($sformatf("vec%0d_param", v), param_out, vecs[v].exp_param);
            check($sformatf("vec%0d_sat", v), 64'(sat_flag), 64'(vecs[v].exp_sat));
        end

        // acc1 = 0xC00 -> +0x600; acc3 = -1 -> floor(-0.5) = -1
        do_commit("batch", {16'hFBFF, 16'hFF00, 16'h0200, 16'h7FFF});
        do_commit("empty", {16'hFBFF, 16'hFF00, 16'h0200, 16'h7FFF});

        do_init("clear");

        // init_start wins over a same-cycle delta; the delta stays pending
        init_start = 1'b1;
        upd_valid  = 1'b1;
        mode       = 1'b0;
        upd_idx    = 2'd0;
        upd_delta  = 16'h0100;
        #1;
        check("conflict_ready_low", 64'(upd_ready), 64'd0);
        tick();
        init_start = 1'b0;
        #1;
        check("conflict_in_init_ready", 64'(upd_ready), 64'd0);
        tick();
        check("conflict_not_applied", param_out, {4{16'hFC00}});
        check("conflict_done", 64'(done), 64'd1);
        tick();
        upd_valid = 1'b0;
        check("conflict_applied_after", param_out, {16'hFC00, 16'hFC00, 16'hFC00, 16'hFD00});

        // Reset while APPLY is on channel 2
        mode      = 1'b1;
        upd_valid = 1'b1;
        upd_idx   = 2'd3;
        upd_delta = 16'h0400;
        tick();
        upd_valid = 1'b0;
        commit    = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_param", param_out, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        begin
            int late_done = 0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (done || busy) late_done++;
            end
            check("abort_no_done_after", 64'(late_done), 64'd0);
        end
        do_init("post_abort");
        // accumulators were cleared by reset/init: apply leaves params alone
        do_commit("post_abort", {4{16'hFC00}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
